// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register file stage and muldiv_unit.
// master = issuing pipeline side, slave = muldiv_unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic            kill_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] operandA_i;
    logic [XLEN-1:0] operandB_i;
    logic [4:0]      rd_i;
    logic            busy_o;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      rd_o;

    modport master (
        output start_i, kill_i, funct3_i, operandA_i, operandB_i, rd_i,
        input  busy_o, valid_o, result_o, rd_o
    );

    modport slave (
        input  start_i, kill_i, funct3_i, operandA_i, operandB_i, rd_i,
        output busy_o, valid_o, result_o, rd_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier, restoring divider.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int ITER_CNT_W = 6
) (
    input logic          clk_i,
    input logic          reset_i,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t                state, state_nx;
    logic [ITER_CNT_W-1:0] cnt;
    logic [2*XLEN-1:0]     acc;
    logic [XLEN-1:0]       b_mag;
    logic [2:0]            f3;
    logic                  neg_q, neg_r;
    logic [XLEN-1:0]       result_q;
    logic [4:0]            rd_q;

    // Operand decode at the request boundary
    logic            is_div, sgn_a_op, sgn_b_op, sign_a, sign_b;
    logic [XLEN-1:0] a_mag_in, b_mag_in;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign is_div   = bus.funct3_i[2];
    assign sgn_a_op = is_div ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
    assign sgn_b_op = is_div ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
    assign sign_a   = sgn_a_op & bus.operandA_i[XLEN-1];
    assign sign_b   = sgn_b_op & bus.operandB_i[XLEN-1];
    assign a_mag_in = sign_a ? -bus.operandA_i : bus.operandA_i;
    assign b_mag_in = sign_b ? -bus.operandB_i : bus.operandB_i;

    assign div_zero = is_div && (bus.operandB_i == '0);
    assign div_ovf  = is_div && !bus.funct3_i[0]
                      && (bus.operandA_i == {1'b1, {(XLEN-1){1'b0}}})
                      && (bus.operandB_i == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        if (div_zero)
            special_res = bus.funct3_i[1] ? bus.operandA_i : '1;
        else
            special_res = bus.funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

`ifdef MULDIV_FAST_MUL_EN
    logic            ext_a, ext_b;
    logic [63:0]     fast_a, fast_b, fast_prod;
    logic [XLEN-1:0] fast_res;

    assign ext_a     = sgn_a_op & bus.operandA_i[XLEN-1];
    assign ext_b     = sgn_b_op & bus.operandB_i[XLEN-1];
    assign fast_a    = {{32{ext_a}}, bus.operandA_i};
    assign fast_b    = {{32{ext_b}}, bus.operandB_i};
    assign fast_prod = fast_a * fast_b;
    assign fast_res  = (bus.funct3_i[1:0] == 2'b00) ? fast_prod[31:0] : fast_prod[63:32];
`endif

    // One iteration step; acc holds {partial, multiplier} or {remainder, quotient}
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, div_step, prod;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff, quo, rem, iter_res;
    logic              last;

    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_mag};
    assign mul_step = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};

    assign div_ge   = acc[2*XLEN-1:XLEN-1] >= {1'b0, b_mag};
    assign div_diff = acc[2*XLEN-2:XLEN-1] - b_mag;
    assign div_step = {div_ge ? div_diff : acc[2*XLEN-2:XLEN-1], acc[XLEN-2:0], div_ge};

    assign prod = neg_q ? -mul_step : mul_step;
    assign quo  = neg_q ? -div_step[XLEN-1:0] : div_step[XLEN-1:0];
    assign rem  = neg_r ? -div_step[2*XLEN-1:XLEN] : div_step[2*XLEN-1:XLEN];
    assign last = (cnt == ITER_CNT_W'(XLEN-1));

    always_comb begin
        if (state == MUL)
            iter_res = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            iter_res = f3[1] ? rem : quo;
    end

    logic            accept, load_res;
    logic [XLEN-1:0] res_nx;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load_res = 1'b0;
        res_nx   = iter_res;
        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    accept = 1'b1;
                    if (special) begin
                        state_nx = DONE;
                        load_res = 1'b1;
                        res_nx   = special_res;
                    end else if (is_div) begin
                        state_nx = DIV;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_nx = DONE;
                        load_res = 1'b1;
                        res_nx   = fast_res;
`else
                        state_nx = MUL;
`endif
                    end
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_nx = DONE;
                    load_res = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // A flush discards everything, including a same-cycle request
        if (bus.kill_i) begin
            state_nx = IDLE;
            accept   = 1'b0;
            load_res = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cnt      <= '0;
            acc      <= '0;
            b_mag    <= '0;
            f3       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            if (bus.kill_i) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                acc   <= {{XLEN{1'b0}}, a_mag_in};
                b_mag <= b_mag_in;
                f3    <= bus.funct3_i;
                neg_q <= sign_a ^ sign_b;
                neg_r <= sign_a;
                rd_q  <= bus.rd_i;
            end else if (state == MUL) begin
                acc <= mul_step;
                cnt <= cnt + 1'b1;
            end else if (state == DIV) begin
                acc <= div_step;
                cnt <= cnt + 1'b1;
            end
            if (load_res) result_q <= res_nx;
        end
    end

    assign bus.busy_o   = (state != IDLE);
    assign bus.valid_o  = (state == DONE);
    assign bus.result_o = result_q;
    assign bus.rd_o     = rd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (both MULDIV_FAST_MUL_EN builds).
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 32;
`endif
    localparam int DIV_LAT = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32), .ITER_CNT_W(6)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure edges from accept to DONE, check result and hold.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int exp_lat,
                         input string tag);
        int lat;
        @(negedge clk);
        bus.funct3_i   = f;
        bus.operandA_i = a;
        bus.operandB_i = b;
        bus.rd_i       = rd;
        bus.start_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        while (!bus.valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result_o, exp);
        chk({tag, "_rd"}, {27'd0, bus.rd_o}, {27'd0, rd});
        @(posedge clk);
        #1;
        chk({tag, "_valid_drop"}, {31'd0, bus.valid_o}, 32'd0);
        chk({tag, "_busy_drop"}, {31'd0, bus.busy_o}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_hold"}, bus.result_o, exp);
    endtask

    initial begin
        int pulses;
        logic [31:0] seen;
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.kill_i     = 1'b0;
        bus.funct3_i   = 3'b000;
        bus.operandA_i = '0;
        bus.operandB_i = '0;
        bus.rd_i       = '0;
        #12;
        chk("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("rst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_rd", {27'd0, bus.rd_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, MUL_LAT, "mul");
        do_op(3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, MUL_LAT, "mulh");
        do_op(3'b011, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, MUL_LAT, "mulhu");
        do_op(3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, MUL_LAT, "mulhsu");
        do_op(3'b101, 32'd100,      32'd7,        5'd5,  32'd14,       DIV_LAT, "divu");
        do_op(3'b111, 32'd100,      32'd7,        5'd6,  32'd2,        DIV_LAT, "remu");
        do_op(3'b100, 32'hFFFFFF9C, 32'd7,        5'd7,  32'hFFFFFFF2, DIV_LAT, "div_neg");
        do_op(3'b110, 32'hFFFFFF9C, 32'd7,        5'd8,  32'hFFFFFFFE, DIV_LAT, "rem_neg");
        do_op(3'b100, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 0,       "div_by0");
        do_op(3'b110, 32'd5,        32'd0,        5'd11, 32'd5,        0,       "rem_by0");
        do_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 0,       "div_ovf");
        do_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'd0,        0,       "rem_ovf");

        // Kill at iteration 10 with a simultaneous start
        @(negedge clk);
        bus.funct3_i   = 3'b101;
        bus.operandA_i = 32'd100;
        bus.operandB_i = 32'd7;
        bus.rd_i       = 5'd3;
        bus.start_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.kill_i  = 1'b1;
        bus.start_i = 1'b1;
        bus.rd_i    = 5'd5;
        @(posedge clk);
        #1;
        bus.kill_i  = 1'b0;
        bus.start_i = 1'b0;
        chk("kill_busy", {31'd0, bus.busy_o}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.valid_o) pulses++;
        end
        chk("kill_no_valid", 32'(pulses), 32'd0);
        chk("kill_result_held", bus.result_o, 32'd0);
        do_op(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, DIV_LAT, "post_kill");

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        bus.funct3_i   = 3'b100;
        bus.operandA_i = 32'hFFFFFF9C;
        bus.operandB_i = 32'd7;
        bus.rd_i       = 5'd13;
        bus.start_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
        chk("midrst_valid", {31'd0, bus.valid_o}, 32'd0);
        chk("midrst_result", bus.result_o, 32'd0);
        chk("midrst_rd", {27'd0, bus.rd_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start held during busy with a different request: only one completion
        @(negedge clk);
        bus.funct3_i   = 3'b101;
        bus.operandA_i = 32'd100;
        bus.operandB_i = 32'd7;
        bus.rd_i       = 5'd4;
        bus.start_i    = 1'b1;
        @(posedge clk);
        #1;
        bus.funct3_i   = 3'b100;
        bus.operandA_i = 32'd5;
        bus.operandB_i = 32'd0;
        bus.rd_i       = 5'd15;
        pulses = 0;
        seen   = '0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 4) bus.start_i = 1'b0;
            if (bus.valid_o) begin
                pulses++;
                seen = bus.result_o;
            end
        end
        chk("busy_start_pulses", 32'(pulses), 32'd1);
        chk("busy_start_result", seen, 32'd14);
        chk("busy_start_rd", {27'd0, bus.rd_o}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
